arb_req_queue: RTL and testbench
================================

Name: arb_req_queue

Overview:
- Upstream request stage for the two-input grant arbiter (req_0/req_1 in, gnt_0/gnt_1 out, grants one-hot, one-cycle registered decision, grant held while request held).
- Buffers words from two client streams in per-channel FIFOs and drives req_0/req_1 from FIFO occupancy.
- Pops the granted channel onto one shared registered output bus.
- Caps each grant tenure at MAX_BURST words, so channel 0 cannot starve channel 1 despite the arbiter's fixed IDLE priority.

Parameters:
- DATA_W, 8, payload width.
- DEPTH, 4, words per channel FIFO; power of 2, at least 2.
- MAX_BURST, 4, max pops per grant tenure; at least 1.

Ports:
- clock, in, 1, single clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- in0_valid, in, 1, channel 0 write strobe.
- in0_data, in, DATA_W, channel 0 write data.
- in0_ready, out, 1, channel 0 FIFO not full.
- in1_valid, in, 1, channel 1 write strobe.
- in1_data, in, DATA_W, channel 1 write data.
- in1_ready, out, 1, channel 1 FIFO not full.
- req_0, out, 1, registered request to arbiter, channel 0.
- req_1, out, 1, registered request to arbiter, channel 1.
- gnt_0, in, 1, arbiter grant, channel 0.
- gnt_1, in, 1, arbiter grant, channel 1.
- out_valid, out, 1, registered output word valid.
- out_id, out, 1, source channel of the output word.
- out_data, out, DATA_W, output word.

Behaviour:
- Clock and reset: one clock (clock). Reset is asynchronous and active-low (reset_n).
- Values while reset_n is low:
  - FIFOs empty, pointers 0, both FSMs in IDLE, burst counters 0.
  - req_0=0, req_1=0, out_valid=0, out_id=0, out_data=0.
  - in0_ready=0, in1_ready=0.
- After reset release: inX_ready = !fullX. Reset asserted mid-burst discards all buffered data immediately.
- Push rule: push when inX_valid && inX_ready. inX_ready depends only on full, so a pop in the same cycle does not open a slot at full.
- Pop rule:
  - Channel X pops when reqX && gntX && !emptyX.
  - Both grants high is a protocol error: only channel 0 pops.
  - Simultaneous push and pop on one FIFO is legal at any non-full occupancy; occupancy is unchanged.
- Output register: on a pop, the next cycle has out_valid=1, out_id=X, out_data=popped word. With no pop, out_valid=0 and out_id/out_data hold their values.
- Per-channel FSM states:
  - IDLE: req=0.
  - REQ: req=1, waiting for or holding the grant.
  - COOL: req=0, 2-cycle counter.
- Transitions:
  - IDLE -> REQ when occupancy is nonzero.
  - REQ, on a pop, increments burst_cnt.
  - REQ -> COOL on a pop when burst_cnt == MAX_BURST-1, or when occupancy == 1 with no same-cycle push. burst_cnt clears to 0 on entry to COOL.
  - REQ stays in REQ with no pop (grant pending).
  - COOL -> REQ after exactly 2 cycles if occupancy is nonzero, else COOL -> IDLE.
- Why COOL is 2 cycles:
  - Cycle 1: the arbiter sees req low and returns to IDLE.
  - Cycle 2: the arbiter in IDLE can grant the other channel before this channel re-requests.
- Latency with the arbiter attached, push into empty channel 0 in cycle t:
  - Occupancy is 1 in cycle t+1.
  - req_0=1 in cycle t+2.
  - gnt_0=1 and pop in cycle t+3.
  - out_valid=1 in cycle t+4.
- Sustained burst: one word per cycle, up to MAX_BURST words.
- Pointers: log2(DEPTH) bits plus 1 wrap bit. Occupancy ranges 0..DEPTH. full = occupancy==DEPTH; empty = occupancy==0.

Test Plan:
- Latency: DEPTH=4, MAX_BURST=4, push 0xA5 on ch0 in cycle 0 -> req_0 high cycle 2, gnt_0 cycle 3, out_valid=1, out_id=0, out_data=0xA5 in cycle 4 only; req_0 low from cycle 4, for 2 cycles, then IDLE.
- Burst cap: preload ch0 with 4 words 0x10..0x13, then keep pushing 0x14,0x15 -> outputs 0x10..0x13 back-to-back, req_0 low 2 cycles, then 0x14,0x15.
- Fairness: preload 4 words in each channel, assert both at once -> ch0 burst of 4 (out_id=0), then ch1 burst of 4 (out_id=1); ch1 grant begins before ch0 re-requests.
- Backpressure: no arbiter grant (gnt tied 0), push 5 words on ch1 -> in1_ready low after the 4th push; 5th word not accepted; occupancy stays 4.
- Reset mid-burst: drop reset_n during the 2nd word of a burst -> req, out_valid, in_ready go 0 asynchronously; after release both FIFOs are empty and no stale word is ever output.
- Push during pop: ch0 occupancy 1, push 0x55 in the same cycle as the pop -> no COOL entry; burst continues and 0x55 appears the next cycle.

Source files
------------

// File: rtl/arb_req_queue.sv
// Upstream request stage for the two-input grant arbiter: per-channel FIFOs,
// request FSMs with burst capping, and one shared registered output bus.
module arb_req_queue #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              req_0,
  output logic              req_1,
  input  logic              gnt_0,
  input  logic              gnt_1,
  output logic              out_valid,
  output logic              out_id,
  output logic [DATA_W-1:0] out_data
);

  // state | meaning
  // IDLE  | FIFO empty, req low
  // REQ   | req high, waiting for or holding the grant
  // COOL  | req low for 2 cycles so the arbiter can serve the other channel

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [AW:0]   OCC_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE    = (AW+1)'(1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, COOL = 2'd2} state_t;

  logic [1:0]        in_valid, in_ready, push, pop, gnt, req, empty;
  logic [DATA_W-1:0] in_data [2];
  logic [DATA_W-1:0] rd_data [2];

  assign in_valid   = {in1_valid, in0_valid};
  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;
  assign gnt        = {gnt_1, gnt_0};
  assign in0_ready  = in_ready[0];
  assign in1_ready  = in_ready[1];
  assign req_0      = req[0];
  assign req_1      = req[1];

  // Both grants high is illegal; channel 0 wins so the pops stay exclusive.
  assign pop[0] = req[0] & gnt[0] & ~empty[0];
  assign pop[1] = req[1] & gnt[1] & ~gnt[0] & ~empty[1];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, occ;
    state_t            state, state_nxt;
    logic [BW-1:0]     burst_cnt, burst_nxt;
    logic              cool_cnt, cool_nxt;

    assign occ         = wr_ptr - rd_ptr;
    assign empty[g]    = (occ == '0);
    assign in_ready[g] = reset_n & (occ != OCC_FULL);
    assign push[g]     = in_valid[g] & in_ready[g];
    assign req[g]      = (state == REQ);
    assign rd_data[g]  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
      if (push[g]) mem[wr_ptr[AW-1:0]] <= in_data[g];
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        state     <= IDLE;
        burst_cnt <= '0;
        cool_cnt  <= 1'b0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
        state     <= state_nxt;
        burst_cnt <= burst_nxt;
        cool_cnt  <= cool_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      burst_nxt = burst_cnt;
      cool_nxt  = cool_cnt;
      case (state)
        IDLE: if (!empty[g]) state_nxt = REQ;
        REQ: begin
          if (pop[g]) begin
            burst_nxt = burst_cnt + BW'(1);
            // Leave on the burst cap, or when this pop drains the FIFO.
            if (burst_cnt == BURST_LAST || (occ == OCC_ONE && !push[g])) begin
              state_nxt = COOL;
              burst_nxt = '0;
              cool_nxt  = 1'b0;
            end
          end
        end
        COOL: begin
          cool_nxt = 1'b1;
          if (cool_cnt) begin
            cool_nxt  = 1'b0;
            state_nxt = empty[g] ? IDLE : REQ;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= |pop;
      if (pop[0]) begin
        out_id   <= 1'b0;
        out_data <= rd_data[0];
      end else if (pop[1]) begin
        out_id   <= 1'b1;
        out_data <= rd_data[1];
      end
    end
  end

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue with a behavioural two-input grant arbiter
// (fixed channel-0 priority from idle, grant held while request held).
module tb_arb_req_queue;

  logic       clock, reset_n;
  logic       in0_valid, in0_ready, in1_valid, in1_ready;
  logic [7:0] in0_data, in1_data, out_data;
  logic       req_0, req_1, gnt_0, gnt_1;
  logic       out_valid, out_id;
  logic       arb_en;
  logic [1:0] arb;
  int         n_checks, n_fail;

  localparam logic [1:0] A_IDLE = 2'd0, A_G0 = 2'd1, A_G1 = 2'd2;

  arb_req_queue #(.DATA_W(8), .DEPTH(4), .MAX_BURST(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .req_0(req_0), .req_1(req_1), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .out_valid(out_valid), .out_id(out_id), .out_data(out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Arbiter model; arb_en low ties both grants off.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) arb <= A_IDLE;
    else if (!arb_en) arb <= A_IDLE;
    else begin
      case (arb)
        A_IDLE:  arb <= req_0 ? A_G0 : (req_1 ? A_G1 : A_IDLE);
        A_G0:    arb <= req_0 ? A_G0 : A_IDLE;
        A_G1:    arb <= req_1 ? A_G1 : A_IDLE;
        default: arb <= A_IDLE;
      endcase
    end
  end
  assign gnt_0 = (arb == A_G0);
  assign gnt_1 = (arb == A_G1);

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic id, input logic [7:0] d);
    if (v) chk(tag, {22'd0, out_valid, out_id, out_data}, {22'd0, v, id, d});
    else   chk(tag, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; arb_en = 1'b1;
    in0_valid = 1'b0; in0_data = '0; in1_valid = 1'b0; in1_data = '0;
    #3;
    chk("rst_req_0", req_0, 0);
    chk("rst_req_1", req_1, 0);
    chk("rst_out", {out_valid, out_id, out_data}, 0);
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    step; step;
    reset_n = 1'b1; #1;
    chk("rel_in0_ready", in0_ready, 1);
    chk("rel_in1_ready", in1_ready, 1);

    // Latency: push 0xA5 into empty channel 0
    step; in0_valid = 1'b1; in0_data = 8'hA5;                       // c0
    step; in0_valid = 1'b0; chk("lat_c1_req", req_0, 0);            // c1
    step; chk("lat_c2_req", req_0, 1); chk_out("lat_c2_out", 0, 0, 0);
    step; chk("lat_c3_req", req_0, 1); chk_out("lat_c3_out", 0, 0, 0);
    step; chk("lat_c4_req", req_0, 0); chk_out("lat_c4_out", 1, 0, 8'hA5);
    step; chk("lat_c5_req", req_0, 0); chk_out("lat_c5_out", 0, 0, 0);
    step; chk("lat_c6_req", req_0, 0);
    step; chk("lat_c7_req", req_0, 0); chk_out("lat_c7_out", 0, 0, 0);

    // Burst cap: 0x10..0x15 pushed back-to-back on channel 0
    for (int i = 0; i < 6; i++) begin
      step; in0_valid = 1'b1; in0_data = 8'h10 + 8'(i);             // c0..c5
      if (i >= 4) chk_out("cap_early", 1, 0, 8'h10 + 8'(i - 4));
    end
    step; in0_valid = 1'b0; chk_out("cap_c6", 1, 0, 8'h12);
    step; chk_out("cap_c7", 1, 0, 8'h13); chk("cap_c7_req", req_0, 0);
    step; chk_out("cap_c8", 0, 0, 0);     chk("cap_c8_req", req_0, 0);
    step; chk_out("cap_c9", 0, 0, 0);     chk("cap_c9_req", req_0, 1);
    step; chk_out("cap_c10", 0, 0, 0);
    step; chk_out("cap_c11", 1, 0, 8'h14); chk("cap_c11_req", req_0, 1);
    step; chk_out("cap_c12", 1, 0, 8'h15); chk("cap_c12_req", req_0, 0);
    step; chk_out("cap_c13", 0, 0, 0);
    repeat (4) step;

    // Fairness: both channels preloaded with grants held off
    arb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step; in0_valid = 1'b1; in0_data = 8'h20 + 8'(i);
      in1_valid = 1'b1; in1_data = 8'h30 + 8'(i);                   // c0..c3
    end
    step; in0_valid = 1'b0; in1_valid = 1'b0; arb_en = 1'b1;        // c4
    chk("fair_c4_req0", req_0, 1); chk("fair_c4_req1", req_1, 1);
    chk("fair_c4_full0", in0_ready, 0);
    step; chk_out("fair_c5", 0, 0, 0);
    step; in0_valid = 1'b1; in0_data = 8'h24; chk_out("fair_c6", 1, 0, 8'h20);
    step; in0_valid = 1'b0; chk_out("fair_c7", 1, 0, 8'h21);
    step; chk_out("fair_c8", 1, 0, 8'h22);
    step; chk_out("fair_c9", 1, 0, 8'h23); chk("fair_c9_req0", req_0, 0);
    step; chk_out("fair_c10", 0, 0, 0);
    step; chk_out("fair_c11", 0, 0, 0); chk("fair_c11_req0", req_0, 1);
    step; chk_out("fair_c12", 1, 1, 8'h30);
    step; chk_out("fair_c13", 1, 1, 8'h31);
    step; chk_out("fair_c14", 1, 1, 8'h32);
    step; chk_out("fair_c15", 1, 1, 8'h33); chk("fair_c15_req1", req_1, 0);
    step; chk_out("fair_c16", 0, 0, 0);
    step; chk_out("fair_c17", 0, 0, 0);
    step; chk_out("fair_c18", 1, 0, 8'h24); chk("fair_c18_req0", req_0, 0);
    repeat (4) step;

    // Backpressure: grants off, five pushes on channel 1
    arb_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step; in1_valid = 1'b1; in1_data = 8'hB0 + 8'(i);             // c0..c4
      chk("bp_ready", in1_ready, (i < 4) ? 1 : 0);
    end
    step; in1_valid = 1'b0; arb_en = 1'b1; chk("bp_c5_ready", in1_ready, 0);
    step; chk_out("bp_c6", 0, 0, 0);
    step; chk_out("bp_c7", 1, 1, 8'hB0); chk("bp_c7_ready", in1_ready, 1);
    step; chk_out("bp_c8", 1, 1, 8'hB1);
    step; chk_out("bp_c9", 1, 1, 8'hB2);
    step; chk_out("bp_c10", 1, 1, 8'hB3);
    for (int i = 0; i < 6; i++) begin
      step; chk_out("bp_drained", 0, 0, 0);
    end

    // Reset asserted while the second word of a burst is popping
    for (int i = 0; i < 3; i++) begin
      step; in0_valid = 1'b1; in0_data = 8'h40 + 8'(i);             // c0..c2
    end
    step; in0_valid = 1'b0;                                         // c3
    step; chk_out("mid_c4", 1, 0, 8'h40);                           // c4
    #2 reset_n = 1'b0; #1;
    chk("mid_req_0", req_0, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in0_ready", in0_ready, 0);
    chk("mid_in1_ready", in1_ready, 0);
    step; step;
    reset_n = 1'b1; #1;
    chk("mid_rel_ready", in0_ready, 1);
    for (int i = 0; i < 8; i++) begin
      step; chk_out("mid_no_stale", 0, 0, 0); chk("mid_no_req", req_0, 0);
    end

    // Push in the same cycle as the pop that empties channel 0
    step; in0_valid = 1'b1; in0_data = 8'h50;                       // c0
    step; in0_valid = 1'b0;                                         // c1
    step;                                                           // c2
    step; in0_valid = 1'b1; in0_data = 8'h55;                       // c3
    step; in0_valid = 1'b0; chk("pp_c4_req", req_0, 1); chk_out("pp_c4", 1, 0, 8'h50);
    step; chk("pp_c5_req", req_0, 0); chk_out("pp_c5", 1, 0, 8'h55);
    step; chk_out("pp_c6", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
